// File: rtl/branch_resolve_ctrl_if.sv
// Request, comparator and redirect signals of the branch resolution block.
// slave is the block's own view; master is the view of the surrounding pipeline.
interface branch_resolve_ctrl_if #(
    parameter int REG_SIZE = 32,
    parameter int SEL_W    = 3,
    parameter int COUNT_W  = 16
);
    logic                br_valid;
    logic                br_ready;
    logic [REG_SIZE-1:0] br_pc;
    logic [REG_SIZE-1:0] br_rs1;
    logic [REG_SIZE-1:0] br_rs2;
    logic [REG_SIZE-1:0] br_imm;
    logic [SEL_W-1:0]    br_sel;
    logic                br_jal;
    logic                br_jalr;
    logic                kill;
    logic [REG_SIZE-1:0] comp_a;
    logic [REG_SIZE-1:0] comp_b;
    logic [SEL_W-1:0]    comp_ctrl;
    logic [REG_SIZE-1:0] comp_result;
    logic                redirect_valid;
    logic                redirect_ready;
    logic [REG_SIZE-1:0] redirect_pc;
    logic                flush;
    logic                resolve_done;
    logic                resolve_taken;
    logic                misalign_err;
    logic [COUNT_W-1:0]  br_count;
    logic [COUNT_W-1:0]  taken_count;

    modport slave (
        input  br_valid, br_pc, br_rs1, br_rs2, br_imm, br_sel, br_jal, br_jalr,
               kill, comp_result, redirect_ready,
        output br_ready, comp_a, comp_b, comp_ctrl, redirect_valid, redirect_pc,
               flush, resolve_done, resolve_taken, misalign_err, br_count, taken_count
    );

    modport master (
        output br_valid, br_pc, br_rs1, br_rs2, br_imm, br_sel, br_jal, br_jalr,
               kill, comp_result, redirect_ready,
        input  br_ready, comp_a, comp_b, comp_ctrl, redirect_valid, redirect_pc,
               flush, resolve_done, resolve_taken, misalign_err, br_count, taken_count
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch/jump resolution sequencer for the RV32I core: drives the shared comparator,
// computes the target and issues a held redirect followed by a flush window.
package risc_v_32i;
    localparam int REG_SIZE          = 32;
    localparam int BRANCH_SEL_LENGTH = 2;
    localparam logic [BRANCH_SEL_LENGTH:0] OP_BEQ     = 3'd0;
    localparam logic [BRANCH_SEL_LENGTH:0] OP_BNE     = 3'd1;
    localparam logic [BRANCH_SEL_LENGTH:0] OP_BLT     = 3'd2;
    localparam logic [BRANCH_SEL_LENGTH:0] OP_BGE     = 3'd3;
    localparam logic [BRANCH_SEL_LENGTH:0] OP_BLTU    = 3'd4;
    localparam logic [BRANCH_SEL_LENGTH:0] OP_BGEU    = 3'd5;
    localparam logic [BRANCH_SEL_LENGTH:0] OP_UNKNOWN = 3'd7;
endpackage

// state    | meaning
// IDLE     | ready for a new branch request
// EVAL     | comparator driven from captured operands, outcome decided
// REDIRECT | redirect_valid/redirect_pc/flush held until fetch accepts
// FLUSH    | flush kept high for FLUSH_CYCLES cycles after the redirect
module branch_resolve_ctrl
    import risc_v_32i::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int COUNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_resolve_ctrl_if.slave bus
);

    localparam int SEL_W = BRANCH_SEL_LENGTH + 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = (FLUSH_CYCLES > 0) ? FC_W'(FLUSH_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, EVAL, REDIRECT, FLUSH} state_t;

    state_t              state_q, state_d;
    logic [REG_SIZE-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                jal_q, jal_d, jalr_q, jalr_d;
    logic                rv_q, rv_d;
    logic [REG_SIZE-1:0] rpc_q, rpc_d;
    logic                flush_q, flush_d;
    logic                done_q, done_d, taken_q, taken_d, mis_q, mis_d;
    logic [COUNT_W-1:0]  br_cnt_q, br_cnt_d, tk_cnt_q, tk_cnt_d;
    logic [FC_W-1:0]     fcnt_q, fcnt_d;

    logic                is_eval;
    logic                taken;
    logic [REG_SIZE-1:0] target;
    logic                unused_result;

    assign unused_result = ^bus.comp_result[REG_SIZE-1:1];

    assign is_eval = (state_q == EVAL);
    assign taken   = jal_q | jalr_q | bus.comp_result[0];
    // jalr clears bit 0 of the sum; both adds wrap at REG_SIZE bits
    assign target  = jalr_q ? ((rs1_q + imm_q) & ~REG_SIZE'(1)) : (pc_q + imm_q);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        sel_d    = sel_q;
        jal_d    = jal_q;
        jalr_d   = jalr_q;
        rv_d     = rv_q;
        rpc_d    = rpc_q;
        flush_d  = flush_q;
        br_cnt_d = br_cnt_q;
        tk_cnt_d = tk_cnt_q;
        fcnt_d   = fcnt_q;
        done_d   = 1'b0;
        taken_d  = 1'b0;
        mis_d    = 1'b0;

        if (bus.kill) begin
            state_d = IDLE;
            rv_d    = 1'b0;
            flush_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.br_valid) begin
                        pc_d    = bus.br_pc;
                        rs1_d   = bus.br_rs1;
                        rs2_d   = bus.br_rs2;
                        imm_d   = bus.br_imm;
                        sel_d   = bus.br_sel;
                        jal_d   = bus.br_jal;
                        jalr_d  = bus.br_jalr;
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    if (!taken) begin
                        done_d   = 1'b1;
                        br_cnt_d = br_cnt_q + COUNT_W'(1);
                        state_d  = IDLE;
                    end else if (target[1:0] != 2'b00) begin
                        mis_d    = 1'b1;
                        done_d   = 1'b1;
                        br_cnt_d = br_cnt_q + COUNT_W'(1);
                        state_d  = IDLE;
                    end else begin
                        rv_d    = 1'b1;
                        rpc_d   = target;
                        flush_d = 1'b1;
                        state_d = REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        rv_d     = 1'b0;
                        done_d   = 1'b1;
                        taken_d  = 1'b1;
                        br_cnt_d = br_cnt_q + COUNT_W'(1);
                        tk_cnt_d = tk_cnt_q + COUNT_W'(1);
                        if (FLUSH_CYCLES > 0) begin
                            fcnt_d  = FC_LOAD;
                            state_d = FLUSH;
                        end else begin
                            flush_d = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt_q == '0) begin
                        flush_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        fcnt_d = fcnt_q - FC_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    rv_d    = 1'b0;
                    flush_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            sel_q    <= OP_UNKNOWN;
            jal_q    <= 1'b0;
            jalr_q   <= 1'b0;
            rv_q     <= 1'b0;
            rpc_q    <= '0;
            flush_q  <= 1'b0;
            done_q   <= 1'b0;
            taken_q  <= 1'b0;
            mis_q    <= 1'b0;
            br_cnt_q <= '0;
            tk_cnt_q <= '0;
            fcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            sel_q    <= sel_d;
            jal_q    <= jal_d;
            jalr_q   <= jalr_d;
            rv_q     <= rv_d;
            rpc_q    <= rpc_d;
            flush_q  <= flush_d;
            done_q   <= done_d;
            taken_q  <= taken_d;
            mis_q    <= mis_d;
            br_cnt_q <= br_cnt_d;
            tk_cnt_q <= tk_cnt_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign bus.br_ready       = (state_q == IDLE) && !bus.kill;
    assign bus.comp_a         = is_eval ? rs1_q : '0;
    assign bus.comp_b         = is_eval ? rs2_q : '0;
    assign bus.comp_ctrl      = is_eval ? sel_q : OP_UNKNOWN;
    assign bus.redirect_valid = rv_q;
    assign bus.redirect_pc    = rpc_q;
    assign bus.flush          = flush_q;
    assign bus.resolve_done   = done_q;
    assign bus.resolve_taken  = taken_q;
    assign bus.misalign_err   = mis_q;
    assign bus.br_count       = br_cnt_q;
    assign bus.taken_count    = tk_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl with a behavioural comparator alongside.
// Counters are built 4 bits wide so the wrap can be reached in a few dozen cycles.
module tb_branch_resolve_ctrl;
    import risc_v_32i::*;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl_if #(.REG_SIZE(32), .SEL_W(3), .COUNT_W(CW)) bus();

    branch_resolve_ctrl #(.FLUSH_CYCLES(2), .COUNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // comparator that sits next to the block in the core
    always_comb begin
        bus.comp_result = '0;
        case (bus.comp_ctrl)
            OP_BEQ:  bus.comp_result[0] = (bus.comp_a == bus.comp_b);
            OP_BNE:  bus.comp_result[0] = (bus.comp_a != bus.comp_b);
            OP_BLT:  bus.comp_result[0] = ($signed(bus.comp_a) <  $signed(bus.comp_b));
            OP_BGE:  bus.comp_result[0] = ($signed(bus.comp_a) >= $signed(bus.comp_b));
            OP_BLTU: bus.comp_result[0] = (bus.comp_a <  bus.comp_b);
            OP_BGEU: bus.comp_result[0] = (bus.comp_a >= bus.comp_b);
            default: bus.comp_result[0] = 1'b0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive a request at a negedge; returns at the negedge of the EVAL cycle
    task automatic issue(input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [2:0] sel,
                         input logic jal, input logic jalr);
        @(negedge clk);
        bus.br_pc    = pc;
        bus.br_rs1   = rs1;
        bus.br_rs2   = rs2;
        bus.br_imm   = imm;
        bus.br_sel   = sel;
        bus.br_jal   = jal;
        bus.br_jalr  = jalr;
        bus.br_valid = 1'b1;
        @(negedge clk);
        bus.br_valid = 1'b0;
        bus.br_jal   = 1'b0;
        bus.br_jalr  = 1'b0;
    endtask

    initial begin
        bus.br_valid       = 1'b0;
        bus.br_pc          = '0;
        bus.br_rs1         = '0;
        bus.br_rs2         = '0;
        bus.br_imm         = '0;
        bus.br_sel         = OP_UNKNOWN;
        bus.br_jal         = 1'b0;
        bus.br_jalr        = 1'b0;
        bus.kill           = 1'b0;
        bus.redirect_ready = 1'b1;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_br_ready",   32'(bus.br_ready), 32'd1);
        chk("rst_comp_ctrl",  32'(bus.comp_ctrl), 32'(OP_UNKNOWN));
        chk("rst_comp_a",     bus.comp_a, 32'd0);
        chk("rst_rv",         32'(bus.redirect_valid), 32'd0);
        chk("rst_flush",      32'(bus.flush), 32'd0);
        chk("rst_done",       32'(bus.resolve_done), 32'd0);
        chk("rst_br_count",   32'(bus.br_count), 32'd0);
        chk("rst_tk_count",   32'(bus.taken_count), 32'd0);
        rst = 1'b0;

        // BEQ taken, redirect accepted immediately
        issue(32'h100, 32'd5, 32'd5, 32'h20, OP_BEQ, 1'b0, 1'b0);
        chk("beq_eval_ctrl",  32'(bus.comp_ctrl), 32'(OP_BEQ));
        chk("beq_eval_a",     bus.comp_a, 32'd5);
        chk("beq_eval_b",     bus.comp_b, 32'd5);
        chk("beq_eval_ready", 32'(bus.br_ready), 32'd0);
        @(negedge clk);
        chk("beq_rv",         32'(bus.redirect_valid), 32'd1);
        chk("beq_rpc",        bus.redirect_pc, 32'h120);
        chk("beq_flush0",     32'(bus.flush), 32'd1);
        chk("beq_no_done",    32'(bus.resolve_done), 32'd0);
        @(negedge clk);
        chk("beq_rv_drop",    32'(bus.redirect_valid), 32'd0);
        chk("beq_flush1",     32'(bus.flush), 32'd1);
        chk("beq_done",       32'(bus.resolve_done), 32'd1);
        chk("beq_taken",      32'(bus.resolve_taken), 32'd1);
        chk("beq_br_count",   32'(bus.br_count), 32'd1);
        chk("beq_tk_count",   32'(bus.taken_count), 32'd1);
        @(negedge clk);
        chk("beq_flush2",     32'(bus.flush), 32'd1);
        chk("beq_done_pulse", 32'(bus.resolve_done), 32'd0);
        @(negedge clk);
        chk("beq_flush_end",  32'(bus.flush), 32'd0);
        chk("beq_idle_ready", 32'(bus.br_ready), 32'd1);

        // BLT signed: -1 < 1 taken
        issue(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, OP_BLT, 1'b0, 1'b0);
        @(negedge clk);
        chk("blt_rv",         32'(bus.redirect_valid), 32'd1);
        chk("blt_rpc",        bus.redirect_pc, 32'h208);
        @(negedge clk);
        chk("blt_taken",      32'(bus.resolve_taken), 32'd1);
        chk("blt_br_count",   32'(bus.br_count), 32'd2);
        chk("blt_tk_count",   32'(bus.taken_count), 32'd2);
        @(negedge clk);
        @(negedge clk);
        chk("blt_flush_end",  32'(bus.flush), 32'd0);

        // BLTU same operands: not taken
        issue(32'h200, 32'hFFFF_FFFF, 32'd1, 32'h8, OP_BLTU, 1'b0, 1'b0);
        @(negedge clk);
        chk("bltu_done",      32'(bus.resolve_done), 32'd1);
        chk("bltu_taken",     32'(bus.resolve_taken), 32'd0);
        chk("bltu_flush",     32'(bus.flush), 32'd0);
        chk("bltu_rv",        32'(bus.redirect_valid), 32'd0);
        chk("bltu_br_count",  32'(bus.br_count), 32'd3);
        chk("bltu_tk_count",  32'(bus.taken_count), 32'd2);

        // JALR to 0x203 -> 0x202, misaligned
        issue(32'h50, 32'h203, 32'd0, 32'd0, OP_UNKNOWN, 1'b0, 1'b1);
        @(negedge clk);
        chk("jalr_mis",       32'(bus.misalign_err), 32'd1);
        chk("jalr_done",      32'(bus.resolve_done), 32'd1);
        chk("jalr_taken",     32'(bus.resolve_taken), 32'd0);
        chk("jalr_rv",        32'(bus.redirect_valid), 32'd0);
        chk("jalr_flush",     32'(bus.flush), 32'd0);
        chk("jalr_br_count",  32'(bus.br_count), 32'd4);
        chk("jalr_tk_count",  32'(bus.taken_count), 32'd2);
        @(negedge clk);
        chk("jalr_mis_pulse", 32'(bus.misalign_err), 32'd0);

        // BNE taken with backward offset, fetch stalls 5 cycles
        bus.redirect_ready = 1'b0;
        issue(32'h300, 32'd1, 32'd2, 32'hFFFF_FFF0, OP_BNE, 1'b0, 1'b0);
        @(negedge clk);
        chk("bne_rv",         32'(bus.redirect_valid), 32'd1);
        chk("bne_rpc",        bus.redirect_pc, 32'h2F0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bne_hold_rv",    32'(bus.redirect_valid), 32'd1);
            chk("bne_hold_rpc",   bus.redirect_pc, 32'h2F0);
            chk("bne_hold_flush", 32'(bus.flush), 32'd1);
            chk("bne_hold_done",  32'(bus.resolve_done), 32'd0);
        end
        bus.redirect_ready = 1'b1;
        @(negedge clk);
        chk("bne_done",       32'(bus.resolve_done), 32'd1);
        chk("bne_taken",      32'(bus.resolve_taken), 32'd1);
        chk("bne_rv_drop",    32'(bus.redirect_valid), 32'd0);
        chk("bne_br_count",   32'(bus.br_count), 32'd5);
        chk("bne_tk_count",   32'(bus.taken_count), 32'd3);
        @(negedge clk);
        @(negedge clk);
        chk("bne_flush_end",  32'(bus.flush), 32'd0);

        // unknown compare, not a jump: not taken
        issue(32'h40, 32'd0, 32'd0, 32'h10, OP_UNKNOWN, 1'b0, 1'b0);
        @(negedge clk);
        chk("unk_done",       32'(bus.resolve_done), 32'd1);
        chk("unk_taken",      32'(bus.resolve_taken), 32'd0);
        chk("unk_rv",         32'(bus.redirect_valid), 32'd0);
        chk("unk_br_count",   32'(bus.br_count), 32'd6);

        // kill while redirect is pending
        bus.redirect_ready = 1'b0;
        issue(32'h500, 32'd7, 32'd7, 32'h4, OP_BEQ, 1'b0, 1'b0);
        @(negedge clk);
        chk("kill_pre_rv",    32'(bus.redirect_valid), 32'd1);
        bus.kill = 1'b1;
        @(negedge clk);
        chk("kill_rv",        32'(bus.redirect_valid), 32'd0);
        chk("kill_flush",     32'(bus.flush), 32'd0);
        chk("kill_done",      32'(bus.resolve_done), 32'd0);
        chk("kill_br_count",  32'(bus.br_count), 32'd6);
        chk("kill_tk_count",  32'(bus.taken_count), 32'd3);
        bus.kill = 1'b0;
        #1;
        chk("kill_idle_ready", 32'(bus.br_ready), 32'd1);
        @(negedge clk);
        chk("kill_no_rv",     32'(bus.redirect_valid), 32'd0);
        bus.redirect_ready = 1'b1;

        // kill in IDLE blocks acceptance
        bus.br_sel   = OP_BEQ;
        bus.br_rs1   = 32'd9;
        bus.br_rs2   = 32'd9;
        bus.br_valid = 1'b1;
        bus.kill     = 1'b1;
        #1;
        chk("kidle_ready",    32'(bus.br_ready), 32'd0);
        @(negedge clk);
        chk("kidle_not_eval", 32'(bus.comp_ctrl), 32'(OP_UNKNOWN));
        chk("kidle_ready2",   32'(bus.br_ready), 32'd0);
        bus.br_valid = 1'b0;
        bus.kill     = 1'b0;
        @(negedge clk);
        chk("kidle_done",     32'(bus.resolve_done), 32'd0);
        chk("kidle_br_count", 32'(bus.br_count), 32'd6);

        // reset during EVAL
        issue(32'h600, 32'd1, 32'd1, 32'h8, OP_BEQ, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("reval_rv",       32'(bus.redirect_valid), 32'd0);
        chk("reval_flush",    32'(bus.flush), 32'd0);
        chk("reval_done",     32'(bus.resolve_done), 32'd0);
        chk("reval_br_count", 32'(bus.br_count), 32'd0);
        chk("reval_tk_count", 32'(bus.taken_count), 32'd0);
        chk("reval_ready",    32'(bus.br_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("reval_no_rv",    32'(bus.redirect_valid), 32'd0);

        // back-to-back not-taken stream until the 4-bit counter wraps
        bus.br_sel   = OP_BNE;
        bus.br_rs1   = 32'd3;
        bus.br_rs2   = 32'd3;
        bus.br_valid = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("b2b_eval",   32'(bus.comp_ctrl), 32'(OP_BNE));
            @(negedge clk);
            chk("b2b_done",   32'(bus.resolve_done), 32'd1);
            chk("b2b_count",  32'(bus.br_count), 32'(k % 16));
        end
        bus.br_valid = 1'b0;
        @(negedge clk);
        chk("b2b_stop",       32'(bus.comp_ctrl), 32'(OP_UNKNOWN));
        chk("wrap_tk_count",  32'(bus.taken_count), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
